// File: rtl/trigger_clk_ctrl_if.sv
// MMCM-side bundle for the trigger-clock sequencer:
// dynamic phase shift, DRP access, reset and lock.
interface trigger_clk_ctrl_if;
  logic        O_psen;
  logic        O_psincdec;
  logic        I_psdone;
  logic [6:0]  O_drp_addr;
  logic [15:0] O_drp_din;
  logic        O_drp_den;
  logic        O_drp_dwe;
  logic [15:0] I_drp_dout;
  logic        I_drp_drdy;
  logic        O_drp_reset;
  logic        I_locked;

  modport master (
    output O_psen, O_psincdec,
    output O_drp_addr, O_drp_din,
    output O_drp_den, O_drp_dwe,
    output O_drp_reset,
    input  I_psdone, I_drp_dout,
    input  I_drp_drdy, I_locked
  );

  modport slave (
    input  O_psen, O_psincdec,
    input  O_drp_addr, O_drp_din,
    input  O_drp_den, O_drp_dwe,
    input  O_drp_reset,
    output I_psdone, I_drp_dout,
    output I_drp_drdy, I_locked
  );
endinterface

// File: rtl/trigger_clk_ctrl.sv
// Trigger-clock MMCM sequencer: turns register pulses into
// phase shifts, DRP reads and DRP writes with reset/relock.
module trigger_clk_ctrl #(
  parameter int pPS_WIDTH      = 12,
  parameter int pPHASE_WIDTH   = 16,
  parameter int pTIMEOUT_WIDTH = 16
) (
  input  logic                           usb_clk,
  input  logic                           reset_n,
  input  logic                           I_ps_req,
  input  logic signed [pPS_WIDTH-1:0]    I_ps_steps,
  input  logic                           I_drp_req,
  input  logic                           I_drp_we,
  input  logic [6:0]                     I_drp_addr,
  input  logic [15:0]                    I_drp_wdata,
  input  logic                           I_error_clear,
  output logic                           O_busy,
  output logic                           O_done,
  output logic [15:0]                    O_drp_rdata,
  output logic signed [pPHASE_WIDTH-1:0] O_phase,
  output logic                           O_error,
  output logic                           O_req_dropped,
  trigger_clk_ctrl_if.master             mmcm
);

  typedef enum logic [2:0] {
    IDLE, PS_PULSE, PS_WAIT,
    DRP_RST, DRP_ACC, DRP_WAIT, LOCK_WAIT
  } state_t;

  state_t                    state;
  logic [pPS_WIDTH-1:0]      remain;
  logic [pPS_WIDTH-1:0]      mag;
  logic                      we;
  logic [pTIMEOUT_WIDTH-1:0] tcnt;
  logic                      tmo;
  logic                      fin;
  logic                      fail;

  assign tmo    = &tcnt;
  assign O_busy = (state != IDLE);
  assign mag    = I_ps_steps[pPS_WIDTH-1]
                ? -I_ps_steps : I_ps_steps;

  // fin: operation ends this cycle; fail: it ends in error
  always_comb begin
    fin  = 1'b0;
    fail = 1'b0;
    unique case (state)
      PS_WAIT: begin
        if (!mmcm.I_locked) begin
          fin  = 1'b1;
          fail = 1'b1;
        end else if (mmcm.I_psdone) begin
          fin = (remain == pPS_WIDTH'(1));
        end else if (tmo) begin
          fin  = 1'b1;
          fail = 1'b1;
        end
      end
      DRP_WAIT: begin
        if (mmcm.I_drp_drdy) begin
          fin = !we;
        end else if (tmo) begin
          fin  = 1'b1;
          fail = 1'b1;
        end
      end
      LOCK_WAIT: begin
        if (mmcm.I_locked) begin
          fin = 1'b1;
        end else if (tmo) begin
          fin  = 1'b1;
          fail = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      remain           <= '0;
      we               <= 1'b0;
      tcnt             <= '0;
      O_done           <= 1'b0;
      O_drp_rdata      <= '0;
      O_phase          <= '0;
      O_error          <= 1'b0;
      O_req_dropped    <= 1'b0;
      mmcm.O_psen      <= 1'b0;
      mmcm.O_psincdec  <= 1'b0;
      mmcm.O_drp_addr  <= '0;
      mmcm.O_drp_din   <= '0;
      mmcm.O_drp_den   <= 1'b0;
      mmcm.O_drp_dwe   <= 1'b0;
      mmcm.O_drp_reset <= 1'b0;
    end else begin
      O_done <= 1'b0;
      tcnt   <= '0;
      unique case (state)
        IDLE: begin
          if (I_drp_req) begin
            we              <= I_drp_we;
            mmcm.O_drp_addr <= I_drp_addr;
            mmcm.O_drp_din  <= I_drp_wdata;
            if (I_drp_we) begin
              mmcm.O_drp_reset <= 1'b1;
              state            <= DRP_RST;
            end else begin
              mmcm.O_drp_den <= 1'b1;
              mmcm.O_drp_dwe <= 1'b0;
              state          <= DRP_ACC;
            end
            if (I_ps_req) O_req_dropped <= 1'b1;
          end else if (I_ps_req) begin
            if (I_ps_steps == '0) begin
              O_done <= 1'b1;
            end else begin
              remain          <= mag;
              mmcm.O_psincdec <= !I_ps_steps[pPS_WIDTH-1];
              mmcm.O_psen     <= 1'b1;
              state           <= PS_PULSE;
            end
          end
        end
        PS_PULSE: begin
          mmcm.O_psen <= 1'b0;
          state       <= PS_WAIT;
        end
        PS_WAIT: begin
          if (mmcm.I_locked && mmcm.I_psdone) begin
            O_phase <= mmcm.O_psincdec
                     ? O_phase + pPHASE_WIDTH'(1)
                     : O_phase - pPHASE_WIDTH'(1);
            remain  <= remain - pPS_WIDTH'(1);
            if (remain != pPS_WIDTH'(1)) begin
              mmcm.O_psen <= 1'b1;
              state       <= PS_PULSE;
            end
          end else if (mmcm.I_locked && !tmo) begin
            tcnt <= tcnt + pTIMEOUT_WIDTH'(1);
          end
        end
        DRP_RST: begin
          mmcm.O_drp_den <= 1'b1;
          mmcm.O_drp_dwe <= 1'b1;
          state          <= DRP_ACC;
        end
        DRP_ACC: begin
          mmcm.O_drp_den <= 1'b0;
          mmcm.O_drp_dwe <= 1'b0;
          state          <= DRP_WAIT;
        end
        DRP_WAIT: begin
          if (mmcm.I_drp_drdy) begin
            if (we) begin
              mmcm.O_drp_reset <= 1'b0;
              O_phase          <= '0;
              state            <= LOCK_WAIT;
            end else begin
              O_drp_rdata <= mmcm.I_drp_dout;
            end
          end else if (!tmo) begin
            tcnt <= tcnt + pTIMEOUT_WIDTH'(1);
          end
        end
        LOCK_WAIT: begin
          if (!mmcm.I_locked && !tmo)
            tcnt <= tcnt + pTIMEOUT_WIDTH'(1);
        end
      endcase

      if (state != IDLE && (I_ps_req || I_drp_req))
        O_req_dropped <= 1'b1;

      if (fin) begin
        state            <= IDLE;
        O_done           <= 1'b1;
        mmcm.O_psen      <= 1'b0;
        mmcm.O_psincdec  <= 1'b0;
        mmcm.O_drp_addr  <= '0;
        mmcm.O_drp_din   <= '0;
        mmcm.O_drp_den   <= 1'b0;
        mmcm.O_drp_dwe   <= 1'b0;
        mmcm.O_drp_reset <= 1'b0;
        if (fail) O_error <= 1'b1;
      end

      // clear wins over a same-cycle set
      if (I_error_clear) begin
        O_error       <= 1'b0;
        O_req_dropped <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trigger_clk_ctrl.sv
// Directed bench for trigger_clk_ctrl with a small
// behavioural MMCM (psdone, drdy, lock) on the slave side.
module tb_trigger_clk_ctrl;
  localparam int TW = 8;

  logic        usb_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps_req = 1'b0;
  logic [11:0] ps_steps = '0;
  logic        drp_req = 1'b0;
  logic        drp_we = 1'b0;
  logic [6:0]  drp_addr = '0;
  logic [15:0] drp_wdata = '0;
  logic        err_clr = 1'b0;
  logic        busy, done, error, dropped;
  logic [15:0] rdata;
  logic [15:0] phase;

  trigger_clk_ctrl_if mif();

  trigger_clk_ctrl #(
    .pPS_WIDTH(12),
    .pPHASE_WIDTH(16),
    .pTIMEOUT_WIDTH(TW)
  ) dut (
    .usb_clk(usb_clk),
    .reset_n(reset_n),
    .I_ps_req(ps_req),
    .I_ps_steps(ps_steps),
    .I_drp_req(drp_req),
    .I_drp_we(drp_we),
    .I_drp_addr(drp_addr),
    .I_drp_wdata(drp_wdata),
    .I_error_clear(err_clr),
    .O_busy(busy),
    .O_done(done),
    .O_drp_rdata(rdata),
    .O_phase(phase),
    .O_error(error),
    .O_req_dropped(dropped),
    .mmcm(mif)
  );

  always #5 usb_clk = ~usb_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // MMCM model
  bit ps_hold = 1'b0;
  int ps_cnt = 0, d_cnt = 0, l_cnt = 0;
  int psen_n = 0, den_n = 0, dwe_n = 0;
  int dwe_rst_n = 0, rst_hi = 0, done_n = 0;
  bit psen_q = 1'b0, den_q = 1'b0;
  bit psen_long = 1'b0, den_long = 1'b0;
  bit last_incdec = 1'b0;

  initial begin
    mif.I_psdone   = 1'b0;
    mif.I_drp_drdy = 1'b0;
    mif.I_drp_dout = '0;
    mif.I_locked   = 1'b1;
  end

  always @(posedge usb_clk) begin
    mif.I_psdone   <= 1'b0;
    mif.I_drp_drdy <= 1'b0;
    psen_q <= mif.O_psen;
    den_q  <= mif.O_drp_den;
    if (mif.O_psen && psen_q) psen_long <= 1'b1;
    if (mif.O_drp_den && den_q) den_long <= 1'b1;
    if (done) done_n <= done_n + 1;
    if (mif.O_psen) begin
      psen_n      <= psen_n + 1;
      last_incdec <= mif.O_psincdec;
      ps_cnt      <= 4;
    end else if (ps_cnt > 0) begin
      ps_cnt <= ps_cnt - 1;
      if (ps_cnt == 1 && !ps_hold)
        mif.I_psdone <= 1'b1;
    end
    if (mif.O_drp_den) begin
      den_n <= den_n + 1;
      if (mif.O_drp_dwe) dwe_n <= dwe_n + 1;
      if (mif.O_drp_dwe && mif.O_drp_reset)
        dwe_rst_n <= dwe_rst_n + 1;
      d_cnt <= 5;
    end else if (d_cnt > 0) begin
      d_cnt <= d_cnt - 1;
      if (d_cnt == 1) begin
        mif.I_drp_drdy <= 1'b1;
        mif.I_drp_dout <= 16'h1041;
      end
    end
    if (mif.O_drp_reset) begin
      rst_hi       <= rst_hi + 1;
      mif.I_locked <= 1'b0;
      l_cnt        <= 100;
    end else if (!mif.I_locked && l_cnt > 0) begin
      l_cnt <= l_cnt - 1;
      if (l_cnt == 1) mif.I_locked <= 1'b1;
    end
  end

  task automatic req_ps(input logic [11:0] s);
    @(negedge usb_clk);
    ps_req   = 1'b1;
    ps_steps = s;
    @(posedge usb_clk);
    #1 ps_req = 1'b0;
  endtask

  task automatic req_drp(input logic w,
                         input logic [6:0] a,
                         input logic [15:0] d,
                         input logic with_ps);
    @(negedge usb_clk);
    drp_req   = 1'b1;
    drp_we    = w;
    drp_addr  = a;
    drp_wdata = d;
    ps_req    = with_ps;
    ps_steps  = 12'd1;
    @(posedge usb_clk);
    #1;
    drp_req = 1'b0;
    ps_req  = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge usb_clk);
    err_clr = 1'b1;
    @(posedge usb_clk);
    #1 err_clr = 1'b0;
  endtask

  task automatic wait_done(input string tag,
                           input int lim,
                           output int n);
    n = lim;
    for (int i = 0; i < lim; i++) begin
      @(negedge usb_clk);
      if (done) begin
        n = i;
        break;
      end
    end
    chk(tag, 32'(n < lim), 1);
  endtask

  int n, p0, d0, e0, w0, r0, k0, q0;

  initial begin
    repeat (3) @(negedge usb_clk);
    chk("rst_flags",
        {busy, done, error, dropped}, 0);
    chk("rst_mmcm",
        {mif.O_psen, mif.O_drp_den,
         mif.O_drp_dwe, mif.O_drp_reset}, 0);
    chk("rst_data", {rdata, phase}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge usb_clk);

    p0 = psen_n; q0 = done_n;
    req_ps(12'd3);
    wait_done("ps3_done", 200, n);
    chk("ps3_psen", psen_n - p0, 3);
    chk("ps3_incdec", last_incdec, 1);
    chk("ps3_phase", phase, 16'd3);
    repeat (3) @(negedge usb_clk);
    chk("ps3_one_done", done_n - q0, 1);
    chk("ps3_busy", busy, 0);

    e0 = den_n; w0 = dwe_n; r0 = rst_hi; k0 = dwe_rst_n;
    req_drp(1'b1, 7'h09, 16'h0080, 1'b0);
    @(negedge usb_clk);
    chk("wr_rst", mif.O_drp_reset, 1);
    chk("wr_bus", {mif.O_drp_addr, mif.O_drp_din},
        {7'h09, 16'h0080});
    wait_done("wr_done", 400, n);
    chk("wr_lock", mif.I_locked, 1);
    chk("wr_den", den_n - e0, 1);
    chk("wr_dwe_rst", dwe_rst_n - k0, 1);
    chk("wr_rst_cyc", rst_hi - r0, 8);
    chk("wr_phase", phase, 0);
    chk("wr_err", error, 0);

    p0 = psen_n;
    req_ps(12'hFFE);
    wait_done("psm2_done", 200, n);
    chk("psm2_psen", psen_n - p0, 2);
    chk("psm2_incdec", last_incdec, 0);
    chk("psm2_phase", phase, 16'hFFFE);

    p0 = psen_n;
    req_ps(12'd0);
    @(negedge usb_clk);
    chk("ps0_done", done, 1);
    repeat (8) @(negedge usb_clk);
    chk("ps0_psen", psen_n - p0, 0);
    chk("ps0_phase", phase, 16'hFFFE);

    e0 = den_n; w0 = dwe_n; r0 = rst_hi;
    req_drp(1'b0, 7'h08, 16'h0000, 1'b0);
    @(negedge usb_clk);
    chk("rd_addr", mif.O_drp_addr, 7'h08);
    wait_done("rd_done", 100, n);
    chk("rd_data", rdata, 16'h1041);
    chk("rd_den", den_n - e0, 1);
    chk("rd_dwe", dwe_n - w0, 0);
    chk("rd_rst", rst_hi - r0, 0);
    chk("rd_drop", dropped, 0);

    ps_hold = 1'b1;
    req_ps(12'd1);
    wait_done("tmo_done", 600, n);
    chk("tmo_cycles", n, 257);
    chk("tmo_err", error, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_phase", phase, 16'hFFFE);
    ps_hold = 1'b0;
    pulse_clr();
    @(negedge usb_clk);
    chk("tmo_clr", error, 0);

    p0 = psen_n;
    req_drp(1'b0, 7'h08, 16'h0000, 1'b1);
    @(negedge usb_clk);
    chk("col_drop", dropped, 1);
    chk("col_busy", busy, 1);
    wait_done("col_done", 100, n);
    chk("col_psen", psen_n - p0, 0);
    pulse_clr();

    req_drp(1'b1, 7'h09, 16'h0080, 1'b0);
    @(negedge usb_clk);
    ps_req  = 1'b1;
    err_clr = 1'b1;
    @(posedge usb_clk);
    #1;
    ps_req  = 1'b0;
    err_clr = 1'b0;
    @(negedge usb_clk);
    chk("clr_prio", dropped, 0);
    req_ps(12'd2);
    @(negedge usb_clk);
    chk("busy_drop", dropped, 1);
    repeat (15) @(negedge usb_clk);
    chk("lw_state", {busy, mif.O_drp_reset, done},
        3'b100);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_flags",
        {busy, done, error, dropped}, 0);
    chk("arst_bus",
        {mif.O_drp_addr, mif.O_drp_din,
         mif.O_drp_reset}, 0);
    chk("pulse_width", {psen_long, den_long}, 0);
    repeat (2) @(negedge usb_clk);
    reset_n = 1'b1;
    @(negedge usb_clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
